// File: rtl/fmas_sched_pkg.sv
// Shared types and constants for the FMA scheduler slice.
// FMA_LAT is the fixed latency of the FMA pipeline that the credit logic assumes.
package fmas_sched_pkg;

  localparam int FMA_LAT  = 2;
  localparam int NREQ_MAX = 4;
  localparam int ID_W_MAX = 2;

  // One result FIFO entry: which requester issued it, plus the FMA outcome.
  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [31:0]         rslt;
    logic [4:0]          flag;
  } rsp_t;

  // One in-flight slot of the latency-matching shift register.
  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } slot_t;

  // Requester index width, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmas_sched_if.sv
// Bus bundle between the requesters, the scheduler, the FMA pipeline and the
// result consumer. The slave modport is the scheduler's view; master is the
// environment that drives requests, returns FMA results and drains responses.
interface fmas_sched_if #(
  parameter int NREQ = 2
);
  import fmas_sched_pkg::*;

  localparam int ID_W = id_width(NREQ);

  // Requester side
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][31:0] req_x;
  logic [NREQ-1:0][31:0] req_y;
  logic [NREQ-1:0][31:0] req_z;

  // FMA pipeline side
  logic                  fma_req;
  logic [31:0]           fma_x;
  logic [31:0]           fma_y;
  logic [31:0]           fma_z;
  logic [31:0]           fma_rslt;
  logic [4:0]            fma_flag;

  // Response side
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_rslt;
  logic [4:0]            rsp_flag;

  modport master (
    output req_valid, req_x, req_y, req_z,
    output fma_rslt, fma_flag,
    output rsp_ready,
    input  req_ready,
    input  fma_req, fma_x, fma_y, fma_z,
    input  rsp_valid, rsp_id, rsp_rslt, rsp_flag
  );

  modport slave (
    input  req_valid, req_x, req_y, req_z,
    input  fma_rslt, fma_flag,
    input  rsp_ready,
    output req_ready,
    output fma_req, fma_x, fma_y, fma_z,
    output rsp_valid, rsp_id, rsp_rslt, rsp_flag
  );

endinterface

// File: rtl/fmas_rsp_fifo.sv
// First-word-fall-through result FIFO. The head entry lives in its own
// register (so the outputs are clean flops and read as zero after reset);
// the remaining entries sit in a small RAM behind it. Pops on an empty FIFO
// are ignored. The scheduler's credit rule guarantees no push while full.
module fmas_rsp_fifo
  import fmas_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  rsp_t                         push_data,
  input  logic                         pop,
  output rsp_t                         pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  rsp_t             mem [DEPTH];
  rsp_t             head_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic pop_ok;
  logic head_from_push;
  logic head_from_mem;
  logic mem_we;

  // A push goes straight into the head when the head is (or is about to be)
  // free; otherwise it queues in the RAM behind the head.
  assign pop_ok         = pop && (count != '0);
  assign head_from_push = push && ((count == '0) || ((count == CNT_W'(1)) && pop_ok));
  assign head_from_mem  = pop_ok && (count > CNT_W'(1));
  assign mem_we         = push && !head_from_push;

  assign pop_data = head_q;

  // Head register: refilled from the push path or from the RAM on a pop.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
    end else if (head_from_push) begin
      head_q <= push_data;
    end else if (head_from_mem) begin
      head_q <= mem[rd_ptr];
    end
  end

  // Entry storage behind the head.
  // NOTE: the RAM is deliberately not reset; count and the pointers define
  // which words are live, and leaving it out of reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // RAM pointers; DEPTH is a power of two so they wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (mem_we) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (head_from_mem) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy including the head; push and pop together leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fmas_sched.sv
// Round-robin scheduler in front of a fixed-latency FMA pipeline.
// Requesters are granted one at a time; each issue reserves a result FIFO
// slot (credit) so results returning LAT cycles later can always be stored.
// Responses leave in issue order.
//
// The issue cycle counts as pipeline stage 0; the remaining FMA_LAT-1 stages
// are tracked in sr_q. The result of an op issued in cycle N is presented on
// fma_rslt during cycle N+1 and captured by the edge that opens cycle N+2,
// so rsp_valid rises in cycle N+2.
//
// Optional feature: define FMAS_SCHED_PERF_EN to add the perf_issue and
// perf_stall counter outputs.
module fmas_sched
  import fmas_sched_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  fmas_sched_if.slave bus
`ifdef FMAS_SCHED_PERF_EN
  ,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_stall
`endif
);

  localparam int ID_W  = id_width(NREQ);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Arbitration
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic [ID_W:0]    cand;
  logic [NREQ-1:0]  ready;
  logic             issue;

  // Credit tracking
  slot_t            sr_q [FMA_LAT-1];
  slot_t            issue_slot;
  slot_t            tail;
  logic [CNT_W:0]   inflight;
  logic [CNT_W:0]   credit_used;
  logic             issue_ok;

  // Result FIFO
  logic [CNT_W-1:0] fifo_count;
  logic             push_valid;
  rsp_t             push_data;
  rsp_t             head;

  // Ops already issued but not yet in the FIFO hold a reserved slot.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < FMA_LAT - 1; k++) begin
      inflight = inflight + (CNT_W+1)'(sr_q[k].valid);
    end
  end

  // Credits are judged on state before this cycle's pop; reset blocks issue.
  assign credit_used = (CNT_W+1)'(fifo_count) + inflight;
  assign issue_ok    = !reset && (credit_used < (CNT_W+1)'(DEPTH));

  // Round-robin search: first valid requester at or after ptr, wrapping.
  // NOTE: every output of a combinational block gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end
      if (!grant_found && bus.req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // One-hot grant, suppressed when no credit is available.
  always_comb begin
    ready = '0;
    if (issue_ok && grant_found) begin
      ready[grant_idx] = 1'b1;
    end
  end

  assign issue         = |(bus.req_valid & ready);
  assign bus.req_ready = ready;
  assign bus.fma_req   = issue;
  assign bus.fma_x     = bus.req_x[grant_idx];
  assign bus.fma_y     = bus.req_y[grant_idx];
  assign bus.fma_z     = bus.req_z[grant_idx];

  // Round-robin pointer moves past the winner only on an actual transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (issue) begin
      ptr_q <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end
  end

  assign issue_slot = '{valid: issue, id: ID_W_MAX'(grant_idx)};
  assign tail       = sr_q[FMA_LAT-2];

  // Latency-matching shift register; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < FMA_LAT - 1; k++) begin
        sr_q[k] <= '0;
      end
    end else begin
      sr_q[0] <= issue_slot;
      for (int k = 1; k < FMA_LAT - 1; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  // The FIFO's own synchronous reset wins over a push in the same cycle.
  assign push_valid = tail.valid;
  assign push_data  = '{id: tail.id, rslt: bus.fma_rslt, flag: bus.fma_flag};

  fmas_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_valid),
    .push_data (push_data),
    .pop       (bus.rsp_ready),
    .pop_data  (head),
    .count     (fifo_count)
  );

  assign bus.rsp_valid = (fifo_count != '0) && !reset;
  assign bus.rsp_id    = head.id[ID_W-1:0];
  assign bus.rsp_rslt  = head.rslt;
  assign bus.rsp_flag  = head.flag;

  // Id bits above the configured requester width are always zero.
  generate
    if (ID_W < ID_W_MAX) begin : g_id_trim
      logic unused_id_hi;
      assign unused_id_hi = |head.id[ID_W_MAX-1:ID_W];
    end
  endgenerate

`ifdef FMAS_SCHED_PERF_EN
  // Issue count and count of cycles with demand but no issue; both wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (issue) begin
        perf_issue <= perf_issue + 32'd1;
      end
      if ((|bus.req_valid) && !issue) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fmas_sched.sv
// Self-checking bench for fmas_sched (NREQ=2, DEPTH=4). The bench plays the
// FMA pipeline and keeps a reference model: a queue of issued-but-unconsumed
// ops, where the credit rule is simply "outstanding ops < DEPTH" and a
// response becomes visible two cycles after its issue.
// Build with FMAS_SCHED_PERF_EN defined to also exercise the perf counters.
module tb_fmas_sched;
  import fmas_sched_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fmas_sched_if #(.NREQ(NREQ)) bus ();

`ifdef FMAS_SCHED_PERF_EN
  logic [31:0] perf_issue;
  logic [31:0] perf_stall;
`endif

  fmas_sched #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FMAS_SCHED_PERF_EN
    ,
    .perf_issue (perf_issue),
    .perf_stall (perf_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Stand-in FMA unit: known IEEE cases from the directed tests, otherwise a
  // deterministic operand mix so each op carries a distinguishable result.
  function automatic logic [36:0] fma_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] z);
    if (x == 32'h7f80_0001) return {5'h10, 32'h7fc0_0001};
    if (x == 32'h3f80_0000 && y == 32'h4000_0000 && z == 32'h3f80_0000)
      return {5'h00, 32'h4040_0000};
    return {x[4:0] ^ z[4:0], x ^ {y[15:0], y[31:16]} ^ (z + 32'd1)};
  endfunction

  // Result appears the cycle after issue and is captured two cycles after
  // issue; idle cycles drive a poison value.
  logic [36:0] fma_pipe = {5'h1f, 32'hdead_beef};
  always @(posedge clk) begin
    fma_pipe <= bus.fma_req ? fma_ref(bus.fma_x, bus.fma_y, bus.fma_z)
                            : {5'h1f, 32'hdead_beef};
  end
  assign bus.fma_rslt = fma_pipe[31:0];
  assign bus.fma_flag = fma_pipe[36:32];

  // FIFO must never receive a push while holding DEPTH entries.
  always @(negedge clk) begin
    if (!reset && dut.push_valid && (int'(dut.fifo_count) == DEPTH)) begin
      n_errors++;
      $display("FAIL fifo_overflow: push with count %0d (limit %0d) at cycle %0d",
               dut.fifo_count, DEPTH, cyc);
    end
  end

  // Watchdog: the bench has no open-ended waits, but never hang regardless.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    int          id;
    logic [31:0] rslt;
    logic [4:0]  flag;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   m_ptr = 0;

  // Values seen in the most recent cycle, for hand-written sequence checks.
  logic [NREQ-1:0] obs_ready;
  logic            obs_fma_req;
  logic            obs_rsp_valid;
  logic [0:0]      obs_rsp_id;
  logic [31:0]     obs_rsp_rslt;
  logic [4:0]      obs_rsp_flag;
`ifdef FMAS_SCHED_PERF_EN
  logic [31:0]     obs_perf_issue;
  logic [31:0]     obs_perf_stall;
`endif

  // Run one cycle: compare DUT against the model mid-cycle, advance model.
  task automatic step();
    logic            exp_issue;
    int              exp_id;
    logic [NREQ-1:0] exp_ready;
    logic            exp_rsp_valid;
    logic [36:0]     r;
    @(negedge clk);
    exp_issue = 1'b0;
    exp_id    = 0;
    exp_ready = '0;
    if (!reset && q.size() < DEPTH) begin
      for (int i = 0; i < NREQ; i++) begin
        int c;
        c = (m_ptr + i) % NREQ;
        if (!exp_issue && bus.req_valid[c]) begin
          exp_issue = 1'b1;
          exp_id    = c;
        end
      end
    end
    if (exp_issue) exp_ready[exp_id] = 1'b1;
    exp_rsp_valid = 1'b0;
    if (!reset && q.size() > 0) begin
      if (q[0].cyc + 2 <= cyc) exp_rsp_valid = 1'b1;
    end

    obs_ready     = bus.req_ready;
    obs_fma_req   = bus.fma_req;
    obs_rsp_valid = bus.rsp_valid;
    obs_rsp_id    = bus.rsp_id;
    obs_rsp_rslt  = bus.rsp_rslt;
    obs_rsp_flag  = bus.rsp_flag;
`ifdef FMAS_SCHED_PERF_EN
    obs_perf_issue = perf_issue;
    obs_perf_stall = perf_stall;
`endif

    check("req_ready", bus.req_ready, exp_ready);
    check("fma_req", bus.fma_req, exp_issue);
    if (exp_issue) begin
      check("fma_x", bus.fma_x, bus.req_x[exp_id]);
      check("fma_y", bus.fma_y, bus.req_y[exp_id]);
      check("fma_z", bus.fma_z, bus.req_z[exp_id]);
    end
    check("rsp_valid", bus.rsp_valid, exp_rsp_valid);
    if (exp_rsp_valid) begin
      check("rsp_id", bus.rsp_id, q[0].id);
      check("rsp_rslt", bus.rsp_rslt, q[0].rslt);
      check("rsp_flag", bus.rsp_flag, q[0].flag);
    end

    if (reset) begin
      q.delete();
      m_ptr = 0;
    end else begin
      if (exp_rsp_valid && bus.rsp_ready) void'(q.pop_front());
      if (exp_issue) begin
        r = fma_ref(bus.req_x[exp_id], bus.req_y[exp_id], bus.req_z[exp_id]);
        q.push_back('{id: exp_id, rslt: r[31:0], flag: r[36:32], cyc: cyc});
        m_ptr = (exp_id + 1) % NREQ;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NREQ-1:0] valid, input logic rdy);
    bus.req_valid = valid;
    bus.rsp_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[i] = $urandom();
      bus.req_y[i] = $urandom();
      bus.req_z[i] = $urandom();
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] ready;
  } vec_t;

  vec_t vecs[10];
  int   n_iss;

  initial begin
    // Arbitration table from ptr=0 with free credits.
    vecs[0] = '{valid: 2'b00, ready: 2'b00};
    vecs[1] = '{valid: 2'b01, ready: 2'b01};
    vecs[2] = '{valid: 2'b01, ready: 2'b01};
    vecs[3] = '{valid: 2'b11, ready: 2'b10};
    vecs[4] = '{valid: 2'b11, ready: 2'b01};
    vecs[5] = '{valid: 2'b10, ready: 2'b10};
    vecs[6] = '{valid: 2'b10, ready: 2'b10};
    vecs[7] = '{valid: 2'b00, ready: 2'b00};
    vecs[8] = '{valid: 2'b11, ready: 2'b01};
    vecs[9] = '{valid: 2'b11, ready: 2'b10};

    reset = 1'b1;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_z = '0;
    drive(2'b11, 1'b1);
    @(posedge clk);
    #1;

    // Reset holds everything quiet even with requests pending.
    do_reset();
    check("reset_ready", obs_ready, 2'b00);
    check("reset_fma_req", obs_fma_req, 1'b0);
    check("reset_rsp_valid", obs_rsp_valid, 1'b0);
    check("reset_rsp_id", obs_rsp_id, 1'b0);
    check("reset_rsp_rslt", obs_rsp_rslt, 32'h0);
    check("reset_rsp_flag", obs_rsp_flag, 5'h0);

    // Table-driven arbitration.
    drive(2'b00, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      drive(vecs[i].valid, 1'b1);
      step();
      check("arb_vec", obs_ready, vecs[i].ready);
    end
    drive(2'b00, 1'b1);
    repeat (4) step();

    // Single op: 1.0*2.0+1.0.
    do_reset();
    bus.req_x[0] = 32'h3f80_0000;
    bus.req_y[0] = 32'h4000_0000;
    bus.req_z[0] = 32'h3f80_0000;
    drive(2'b01, 1'b1);
    step();
    check("single_fma_req", obs_fma_req, 1'b1);
    drive(2'b00, 1'b1);
    step();
    check("single_c1_rsp_valid", obs_rsp_valid, 1'b0);
    step();
    check("single_c2_rsp_valid", obs_rsp_valid, 1'b1);
    check("single_rsp_id", obs_rsp_id, 1'b0);
    check("single_rsp_rslt", obs_rsp_rslt, 32'h4040_0000);
    check("single_rsp_flag", obs_rsp_flag, 5'h00);
    step();
    check("single_c3_rsp_valid", obs_rsp_valid, 1'b0);

    // Fairness: alternating grants, one issue every cycle.
    do_reset();
    rand_ops();
    drive(2'b11, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("fair_grant", obs_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      check("fair_fma_req", obs_fma_req, 1'b1);
    end
    drive(2'b00, 1'b1);
    repeat (4) step();

    // Backpressure: DEPTH issues, then one more per consumed response.
    do_reset();
    rand_ops();
    drive(2'b11, 1'b0);
    n_iss = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_iss += int'(obs_fma_req);
    end
    check("bp_issues", n_iss, DEPTH);
    check("bp_blocked_ready", obs_ready, 2'b00);
    drive(2'b11, 1'b1);
    step();
    check("bp_pulse_cycle_fma_req", obs_fma_req, 1'b0);
    drive(2'b11, 1'b0);
    step();
    check("bp_after_pulse_fma_req", obs_fma_req, 1'b1);
    n_iss = 0;
    repeat (3) begin
      step();
      n_iss += int'(obs_fma_req);
    end
    check("bp_no_extra_issue", n_iss, 0);
    drive(2'b00, 1'b1);
    repeat (8) step();

    // Order and NaN: req1 sNaN first, then req0 normal op.
    do_reset();
    bus.req_x[1] = 32'h7f80_0001;
    bus.req_y[1] = 32'h3f80_0000;
    bus.req_z[1] = 32'h0000_0000;
    bus.req_x[0] = 32'h3f80_0000;
    bus.req_y[0] = 32'h4000_0000;
    bus.req_z[0] = 32'h3f80_0000;
    drive(2'b10, 1'b0);
    step();
    drive(2'b01, 1'b0);
    step();
    drive(2'b00, 1'b0);
    step();
    check("nan_first_id", obs_rsp_id, 1'b1);
    check("nan_first_rslt", obs_rsp_rslt, 32'h7fc0_0001);
    check("nan_first_flag", obs_rsp_flag, 5'h10);
    drive(2'b00, 1'b1);
    step();
    step();
    check("nan_second_valid", obs_rsp_valid, 1'b1);
    check("nan_second_id", obs_rsp_id, 1'b0);
    check("nan_second_rslt", obs_rsp_rslt, 32'h4040_0000);
    repeat (2) step();

    // Reset one cycle after an issue: nothing may emerge afterwards.
    do_reset();
    rand_ops();
    drive(2'b01, 1'b0);
    step();
    drive(2'b00, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("midreset_rsp_valid", obs_rsp_valid, 1'b0);
    end

`ifdef FMAS_SCHED_PERF_EN
    // Perf counters: 10 issues with 3 credit-stalled cycles in between.
    do_reset();
    check("perf_issue_reset", obs_perf_issue, 32'd0);
    check("perf_stall_reset", obs_perf_stall, 32'd0);
    rand_ops();
    for (int k = 0; k < 13; k++) begin
      drive(2'b11, (k >= 6) ? 1'b1 : 1'b0);
      step();
    end
    drive(2'b00, 1'b1);
    step();
    check("perf_issue", obs_perf_issue, 32'd10);
    check("perf_stall", obs_perf_stall, 32'd3);
    repeat (6) step();
`endif

    // Randomized traffic against the model, with occasional resets.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rand_ops();
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    drive(2'b00, 1'b1);
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fmas_sched.md
FMAS_SCHED -- requirements
Module: fmas_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..4).
REQ-002 SHALL have parameter DEPTH, default 4, result FIFO entries (power of 2, >= 3).
REQ-003 Port clk  input  1  sole clock; all state updates on posedge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  NREQ  per-requester operation valid.
REQ-006 Port req_ready  output  NREQ  per-requester grant; a transfer occurs when valid&ready are both high.
REQ-007 Port req_x / req_y / req_z  input  NREQ x 32  per-requester single-precision operands, FMA computes x*y+z.
REQ-008 Port fma_req  output  1  issue strobe to the FMA pipeline.
REQ-009 Port fma_x / fma_y / fma_z  output  32 each  operands of the granted requester; combinational from the selected inputs.
REQ-010 Port fma_rslt  input  32  FMA result.
REQ-011 Port fma_flag  input  5  FMA exception flags.
REQ-012 Port rsp_valid  output  1  head of result FIFO valid.
REQ-013 Port rsp_ready  input  1  consumer accepts head.
REQ-014 Port rsp_id  output  $clog2(NREQ) (min 1)  requester index of head.
REQ-015 Port rsp_rslt / rsp_flag  output  32 / 5  head result and flags.

Function
REQ-016 FMA pipeline SHALL be treated as fixed latency LAT=2 with no stall: an operation issued with fma_req in cycle N SHALL be captured from fma_rslt/fma_flag in cycle N+2.
REQ-017 SHALL keep an LAT-deep shift register of {valid, id}; a valid entry at its tail pushes {id, fma_rslt, fma_flag} into the FIFO.
REQ-018 Credit rule: issue permitted only when fifo_count + inflight < DEPTH, where inflight counts valid shift-register entries, evaluated before the current cycle's pop.
REQ-019 Arbitration SHALL be round-robin: grant the first valid requester at or after ptr, modulo NREQ; at most one req_ready high per cycle; req_ready SHALL be zero when issue is not permitted.
REQ-020 ptr SHALL advance to (granted index + 1) mod NREQ only on a transfer; it SHALL be held otherwise.
REQ-021 fma_req = OR of (req_valid & req_ready); one issue per cycle sustained when credits allow.
REQ-022 FIFO SHALL be first-word-fall-through: rsp_* driven from the head register; rsp_valid = count != 0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; pop when empty SHALL be ignored; push when full is impossible by REQ-018, and the bench SHALL assert this.
REQ-024 Responses SHALL leave in issue order irrespective of requester.
REQ-025 Pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 On reset SHALL clear the shift register, FIFO count and pointers, and set ptr=0; in-flight FMA results are discarded.
REQ-027 Outputs during and after reset SHALL be req_ready=0 while reset is high, fma_req=0, rsp_valid=0; rsp_id/rslt/flag SHALL be 0 from reset.
REQ-028 Reset asserted mid-operation SHALL take effect on the next edge; pushes due in that cycle SHALL be dropped.

Configuration
REQ-029 Macro FMAS_SCHED_PERF_EN, when defined, SHALL add outputs perf_issue (32) and perf_stall (32): perf_issue increments on each fma_req; perf_stall increments on each cycle where any req_valid is high and fma_req is low; both counters wrap and reset to 0.
REQ-030 Without FMAS_SCHED_PERF_EN these ports and counters SHALL be absent; the remaining behaviour SHALL be identical.

Structure
REQ-031 Package fmas_sched_pkg SHALL hold localparam FMA_LAT=2 and typedef rsp_t {id, rslt[31:0], flag[4:0]}.
REQ-032 The result FIFO SHALL be a sub-module fmas_rsp_fifo (parameter DEPTH, rsp_t push/pop, count output); arbitration and credit logic SHALL stay in fmas_sched.

Verification
REQ-033 Single op: req 0 valid with x=0x3f800000, y=0x40000000, z=0x3f800000 -> fma_req in cycle 0, rsp_valid in cycle 2, rsp_id=0, rsp_rslt=0x40400000, flag=0.
REQ-034 Fairness: both requesters held valid and rsp_ready=1 -> grants alternate 0,1,0,1 with one issue per cycle and no idle cycles.
REQ-035 Backpressure: rsp_ready=0 with DEPTH=4 -> exactly 4 issues, then req_ready=0; a single rsp_ready pulse -> exactly one further issue 1 cycle later, and no FIFO overflow.
REQ-036 Order and NaN: req1 issues x=0x7f800001 (sNaN), then req0 issues a normal op -> responses come out as id1 (rslt=0x7fc00001, flag=0x10), then id0.
REQ-037 Reset mid-flight: reset asserted 1 cycle after an issue -> rsp_valid stays 0 after reset and no stale response appears.
REQ-038 With FMAS_SCHED_PERF_EN: 10 issues and 3 credit-stalled cycles -> perf_issue=10 and perf_stall=3.
